// File: rtl/uart_frame_tx_ctrl.sv
// Frame serialiser for multi-channel ADC samples: header, masked channel bytes MSB first, checksum.
// Hands bytes to the UART byte transmitter via a Byte_En / Tx_Done handshake.
module uart_frame_tx_ctrl #(
    parameter int          DATA_W    = 16,
    parameter int          NUM_CH    = 2,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5,
    parameter logic [7:0]  ADDR_EN   = 8'd4,
    parameter logic [7:0]  ADDR_BAUD = 8'd5,
    parameter logic [7:0]  ADDR_MASK = 8'd6
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       m_wr,
    input  logic [7:0]                 m_addr,
    input  logic [15:0]                m_wrdata,
    input  logic                       ADC_Flag,
    input  logic [NUM_CH*DATA_W-1:0]   ADC_Data,
    input  logic                       Tx_Done,
    output logic                       Byte_En,
    output logic [7:0]                 Tx_Data,
    output logic [2:0]                 Baud_Set,
    output logic                       Busy,
    output logic [7:0]                 Drop_Cnt
);
    localparam int NB = (DATA_W + 7) / 8;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE} state_t;
    typedef enum logic [1:0] {SEL_HDR, SEL_DATA, SEL_CSUM} sel_t;

    state_t                     state_q, state_d;
    sel_t                       sel_q, sel_d, nsel;
    logic [3:0]                 ch_q, ch_d, nch;
    logic [2:0]                 bi_q, bi_d, nbi;
    logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]          mask_q, mask_d;
    logic [2:0]                 baud_q, baud_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic [7:0]                 csum_q, csum_d;
    logic [7:0]                 drop_q, drop_d;
    logic                       en_q, en_d;
    logic [2:0]                 baud_reg_q, baud_reg_d;
    logic [NUM_CH-1:0]          mask_reg_q, mask_reg_d;

    logic [DATA_W-1:0]          sample;
    logic [NB*8-1:0]            sample_ext;
    logic [7:0]                 data_byte;
    logic                       found;
    int                         nxt_c;
    logic                       unused_wrdata;

    assign unused_wrdata = ^m_wrdata;

    // Position of the byte that follows the current one in the frame.
    always_comb begin
        found = 1'b0;
        nxt_c = 0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mask_q[c] && (sel_q == SEL_HDR || c > int'(ch_q))) begin
                found = 1'b1;
                nxt_c = c;
            end
        end
        nsel = sel_q;
        nch  = ch_q;
        nbi  = bi_q;
        case (sel_q)
            SEL_HDR: begin
                nsel = SEL_DATA;
                nch  = 4'(nxt_c);
                nbi  = 3'(NB - 1);
            end
            SEL_DATA: begin
                if (bi_q != 3'd0) begin
                    nbi = bi_q - 3'd1;
                end else if (found) begin
                    nch = 4'(nxt_c);
                    nbi = 3'(NB - 1);
                end else begin
                    nsel = SEL_CSUM;
                end
            end
            default: nsel = SEL_HDR;
        endcase
        sample     = DATA_W'(data_q >> (int'(nch) * DATA_W));
        sample_ext = (NB*8)'(sample);
        data_byte  = 8'(sample_ext >> (int'(nbi) * 8));
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ch_d       = ch_q;
        bi_d       = bi_q;
        data_d     = data_q;
        mask_d     = mask_q;
        baud_d     = baud_q;
        tx_data_d  = tx_data_q;
        csum_d     = csum_q;
        drop_d     = drop_q;
        en_d       = en_q;
        baud_reg_d = baud_reg_q;
        mask_reg_d = mask_reg_q;

        if (m_wr) begin
            if (m_addr == ADDR_EN)   en_d       = m_wrdata[0];
            if (m_addr == ADDR_BAUD) baud_reg_d = m_wrdata[2:0];
            if (m_addr == ADDR_MASK) mask_reg_d = m_wrdata[NUM_CH-1:0];
        end

        if (ADC_Flag && state_q != IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (ADC_Flag && en_q && mask_reg_q != '0) begin
                    data_d    = ADC_Data;
                    mask_d    = mask_reg_q;
                    baud_d    = baud_reg_q;
                    csum_d    = 8'd0;
                    sel_d     = SEL_HDR;
                    ch_d      = 4'd0;
                    bi_d      = 3'd0;
                    tx_data_d = HDR_BYTE;
                    state_d   = STROBE;
                end
            end
            STROBE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (Tx_Done) begin
                    if (sel_q == SEL_CSUM) begin
                        state_d = IDLE;
                    end else begin
                        sel_d   = nsel;
                        ch_d    = nch;
                        bi_d    = nbi;
                        state_d = STROBE;
                        // Checksum accumulates as each data byte is loaded for sending.
                        if (nsel == SEL_CSUM) begin
                            tx_data_d = csum_q;
                        end else begin
                            tx_data_d = data_byte;
                            csum_d    = csum_q + data_byte;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            sel_q      <= SEL_HDR;
            ch_q       <= '0;
            bi_q       <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            baud_q     <= '0;
            tx_data_q  <= '0;
            csum_q     <= '0;
            drop_q     <= '0;
            en_q       <= 1'b1;
            baud_reg_q <= '0;
            mask_reg_q <= '1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ch_q       <= ch_d;
            bi_q       <= bi_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            baud_q     <= baud_d;
            tx_data_q  <= tx_data_d;
            csum_q     <= csum_d;
            drop_q     <= drop_d;
            en_q       <= en_d;
            baud_reg_q <= baud_reg_d;
            mask_reg_q <= mask_reg_d;
        end
    end

    assign Byte_En  = (state_q == STROBE);
    assign Busy     = (state_q != IDLE);
    assign Tx_Data  = tx_data_q;
    assign Baud_Set = baud_q;
    assign Drop_Cnt = drop_q;
endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Directed bench for uart_frame_tx_ctrl with 12-bit samples on two channels.
module tb_uart_frame_tx_ctrl;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = 8'd0;
    logic [15:0] m_wrdata = 16'd0;
    logic        ADC_Flag = 1'b0;
    logic [23:0] ADC_Data = 24'h0;
    logic        Tx_Done = 1'b0;
    logic        Byte_En;
    logic [7:0]  Tx_Data;
    logic [2:0]  Baud_Set;
    logic        Busy;
    logic [7:0]  Drop_Cnt;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] got [8];
    int         got_n;
    int         extra_en;
    bit         tmo;

    logic [7:0] exp_full [6];
    logic [7:0] exp_ch1  [4];
    logic [23:0] sample_a;

    uart_frame_tx_ctrl #(.DATA_W(12), .NUM_CH(2)) dut (
        .Clk(Clk), .Rst(Rst), .m_wr(m_wr), .m_addr(m_addr), .m_wrdata(m_wrdata),
        .ADC_Flag(ADC_Flag), .ADC_Data(ADC_Data), .Tx_Done(Tx_Done),
        .Byte_En(Byte_En), .Tx_Data(Tx_Data), .Baud_Set(Baud_Set), .Busy(Busy),
        .Drop_Cnt(Drop_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_flag;
        ADC_Flag = 1'b1;
        tick();
        ADC_Flag = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [15:0] d);
        m_wr = 1'b1; m_addr = a; m_wrdata = d;
        tick();
        m_wr = 1'b0;
    endtask

    // Answers each Byte_En with Tx_Done 'gap' cycles later until Busy drops.
    // Optionally issues one register write in the gap after byte number wr_at.
    task automatic collect(input int gap, input int wr_at, input logic [7:0] wa, input logic [15:0] wd);
        got_n = 0; extra_en = 0; tmo = 1'b1;
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (Byte_En) begin
                if (got_n < 8) got[got_n] = Tx_Data;
                got_n++;
                if (got_n == wr_at) begin m_wr = 1'b1; m_addr = wa; m_wrdata = wd; end
                for (int g = 1; g < gap; g++) begin
                    tick();
                    m_wr = 1'b0;
                    if (Byte_En) extra_en++;
                end
                Tx_Done = 1'b1;
                tick();
                Tx_Done = 1'b0;
            end else begin
                tick();
            end
            if (!Busy) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; tick(); tick(); Rst = 1'b0;
        compared++; if (Byte_En !== 1'b0) begin mismatched++; $display("FAIL reset_byte_en got %b want 0", Byte_En); end
        compared++; if (Tx_Data !== 8'h00) begin mismatched++; $display("FAIL reset_tx_data got %h want 00", Tx_Data); end
        compared++; if (Baud_Set !== 3'd0) begin mismatched++; $display("FAIL reset_baud got %0d want 0", Baud_Set); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", Busy); end
        compared++; if (Drop_Cnt !== 8'd0) begin mismatched++; $display("FAIL reset_drop got %0d want 0", Drop_Cnt); end
    endtask

    task automatic test_basic;
        ADC_Data = sample_a;
        pulse_flag();
        compared++; if (Byte_En !== 1'b1) begin mismatched++; $display("FAIL hdr_latency byte_en got %b want 1", Byte_En); end
        compared++; if (Tx_Data !== 8'hA5) begin mismatched++; $display("FAIL hdr_byte got %h want a5", Tx_Data); end
        compared++; if (Busy !== 1'b1) begin mismatched++; $display("FAIL busy_start got %b want 1", Busy); end
        collect(5, -1, 8'd0, 16'd0);
        compared++; if (tmo) begin mismatched++; $display("FAIL basic_timeout got busy want idle"); end
        compared++; if (got_n !== 6) begin mismatched++; $display("FAIL basic_len got %0d want 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (got[i] !== exp_full[i]) begin mismatched++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_full[i]); end
        end
        compared++; if (extra_en !== 0) begin mismatched++; $display("FAIL basic_strobe_width got %0d extra want 0", extra_en); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_end got %b want 0", Busy); end
    endtask

    task automatic test_mask;
        wr_reg(8'd6, 16'h0002);
        pulse_flag();
        collect(5, -1, 8'd0, 16'd0);
        compared++; if (got_n !== 4 || tmo) begin mismatched++; $display("FAIL mask_len got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (got[i] !== exp_ch1[i]) begin mismatched++; $display("FAIL mask_byte%0d got %h want %h", i, got[i], exp_ch1[i]); end
        end
        wr_reg(8'd6, 16'h0000);
        pulse_flag();
        begin
            int seen = 0;
            if (Byte_En) seen++;
            for (int i = 0; i < 6; i++) begin tick(); if (Byte_En || Busy) seen++; end
            compared++; if (seen !== 0) begin mismatched++; $display("FAIL mask0_no_frame got %0d active cycles want 0", seen); end
        end
        compared++; if (Drop_Cnt !== 8'd0) begin mismatched++; $display("FAIL mask0_drop got %0d want 0", Drop_Cnt); end
        wr_reg(8'd6, 16'h0003);
    endtask

    task automatic test_baud;
        pulse_flag();
        collect(5, 2, 8'd5, 16'h0003);
        compared++; if (got_n !== 6 || tmo) begin mismatched++; $display("FAIL baud_frame_len got %0d want 6", got_n); end
        compared++; if (Baud_Set !== 3'd0) begin mismatched++; $display("FAIL baud_midframe got %0d want 0", Baud_Set); end
        pulse_flag();
        compared++; if (Baud_Set !== 3'd3) begin mismatched++; $display("FAIL baud_next_frame got %0d want 3", Baud_Set); end
        collect(5, -1, 8'd0, 16'd0);
        compared++; if (got[5] !== 8'hEA) begin mismatched++; $display("FAIL baud_csum got %h want ea", got[5]); end
    endtask

    task automatic test_enable;
        pulse_flag();
        collect(5, 2, 8'd4, 16'h0000);
        compared++; if (got_n !== 6 || tmo) begin mismatched++; $display("FAIL en_frame_len got %0d want 6", got_n); end
        compared++; if (got[5] !== 8'hEA) begin mismatched++; $display("FAIL en_csum got %h want ea", got[5]); end
        pulse_flag();
        begin
            int seen = 0;
            if (Byte_En) seen++;
            for (int i = 0; i < 6; i++) begin tick(); if (Byte_En || Busy) seen++; end
            compared++; if (seen !== 0) begin mismatched++; $display("FAIL en_off_no_frame got %0d active cycles want 0", seen); end
        end
        compared++; if (Drop_Cnt !== 8'd0) begin mismatched++; $display("FAIL en_off_drop got %0d want 0", Drop_Cnt); end
        wr_reg(8'd4, 16'h0001);
    endtask

    task automatic test_drop;
        pulse_flag();
        compared++; if (Tx_Data !== 8'hA5) begin mismatched++; $display("FAIL drop_hdr got %h want a5", Tx_Data); end
        ADC_Data = 24'hFFF_FFF;
        for (int i = 0; i < 300; i++) begin
            ADC_Flag = 1'b1; tick(); ADC_Flag = 1'b0; tick();
            if (i == 99) begin
                compared++; if (Drop_Cnt !== 8'd100) begin mismatched++; $display("FAIL drop_100 got %0d want 100", Drop_Cnt); end
            end
        end
        compared++; if (Drop_Cnt !== 8'd255) begin mismatched++; $display("FAIL drop_sat got %0d want 255", Drop_Cnt); end
        ADC_Data = sample_a;
        Tx_Done = 1'b1; tick(); Tx_Done = 1'b0;
        collect(5, -1, 8'd0, 16'd0);
        compared++; if (got_n !== 5 || tmo) begin mismatched++; $display("FAIL drop_rest_len got %0d want 5", got_n); end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (got[i] !== exp_full[i+1]) begin mismatched++; $display("FAIL drop_byte%0d got %h want %h", i+1, got[i], exp_full[i+1]); end
        end
    endtask

    task automatic test_rst_mid;
        pulse_flag();
        tick();
        Tx_Done = 1'b1; tick(); Tx_Done = 1'b0;
        tick();
        Tx_Done = 1'b1; tick(); Tx_Done = 1'b0;
        compared++; if (Tx_Data !== 8'hBC) begin mismatched++; $display("FAIL rst_pre_byte3 got %h want bc", Tx_Data); end
        tick();
        Rst = 1'b1; tick(); Rst = 1'b0;
        compared++; if (Byte_En !== 1'b0) begin mismatched++; $display("FAIL rst_mid_byte_en got %b want 0", Byte_En); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got %b want 0", Busy); end
        compared++; if (Baud_Set !== 3'd0) begin mismatched++; $display("FAIL rst_mid_baud got %0d want 0", Baud_Set); end
        compared++; if (Drop_Cnt !== 8'd0) begin mismatched++; $display("FAIL rst_mid_drop got %0d want 0", Drop_Cnt); end
        Tx_Done = 1'b1; tick(); Tx_Done = 1'b0;
        begin
            int seen = 0;
            if (Byte_En || Busy) seen++;
            for (int i = 0; i < 5; i++) begin tick(); if (Byte_En || Busy) seen++; end
            compared++; if (seen !== 0) begin mismatched++; $display("FAIL rst_stale_done got %0d active cycles want 0", seen); end
        end
        pulse_flag();
        compared++; if (Byte_En !== 1'b1 || Tx_Data !== 8'hA5) begin mismatched++; $display("FAIL rst_new_hdr got en=%b data=%h want en=1 data=a5", Byte_En, Tx_Data); end
        collect(5, -1, 8'd0, 16'd0);
        compared++; if (got_n !== 6 || tmo) begin mismatched++; $display("FAIL rst_new_len got %0d want 6", got_n); end
        compared++; if (got[5] !== 8'hEA) begin mismatched++; $display("FAIL rst_new_csum got %h want ea", got[5]); end
    endtask

    initial begin
        sample_a = {12'h123, 12'hABC};
        exp_full[0] = 8'hA5; exp_full[1] = 8'h0A; exp_full[2] = 8'hBC;
        exp_full[3] = 8'h01; exp_full[4] = 8'h23; exp_full[5] = 8'hEA;
        exp_ch1[0] = 8'hA5; exp_ch1[1] = 8'h01; exp_ch1[2] = 8'h23; exp_ch1[3] = 8'h24;
        test_reset();
        test_basic();
        test_mask();
        test_baud();
        test_enable();
        test_drop();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
